// File: rtl/osc_trigger_capture.sv
// Trigger-and-capture stage: watches the signed sample stream for a level
// crossing on the selected slope, records DEPTH samples around it (with a
// programmable pre-trigger count) and streams the record out oldest-first.
module osc_trigger_capture #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              arm,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic [ADDR_W-1:0] pretrig,
    output logic              armed,
    output logic              triggered,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_READ = 3'd4;

    logic [2:0]               state;
    logic [2:0]               state_next;
    logic [DATA_W-1:0]        mem [DEPTH];
    logic [ADDR_W-1:0]        wr_ptr;
    logic [ADDR_W-1:0]        fill_cnt;
    logic [ADDR_W-1:0]        pre_n;
    logic [ADDR_W-1:0]        trig_ptr;
    logic [ADDR_W-1:0]        post_cnt;
    logic [ADDR_W-1:0]        post_load;
    logic [ADDR_W-1:0]        rd_addr;
    logic [CNT_W-1:0]         fetch_cnt;
    logic signed [DATA_W-1:0] prev;
    logic signed [DATA_W-1:0] level;
    logic                     slope;
    logic                     prev_valid;
    logic                     addr_ok;
    logic                     wr_en;
    logic                     trig_hit;
    logic                     rd_load;
    logic                     rd_accept;

    // Write enable, trigger detection and readout handshake decode
    always_comb begin
        wr_en     = 1'b0;
        trig_hit  = 1'b0;
        post_load = ADDR_W'(DEPTH - 1) - pre_n;
        rd_accept = rd_valid && rd_ready;
        rd_load   = 1'b0;
        if ((state == S_PRE) || (state == S_WAIT) || (state == S_POST)) begin
            wr_en = sample_valid;
        end
        if ((state == S_WAIT) && sample_valid && prev_valid) begin
            if (slope) begin
                trig_hit = (prev > level) && ($signed(sample_in) <= level);
            end else begin
                trig_hit = (prev < level) && ($signed(sample_in) >= level);
            end
        end
        if ((state == S_READ) && addr_ok && (fetch_cnt != CNT_W'(DEPTH))
            && (!rd_valid || rd_ready)) begin
            rd_load = 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (arm) begin
                    state_next = (pretrig == '0) ? S_WAIT : S_PRE;
                end
            end
            S_PRE: begin
                if (sample_valid && (ADDR_W'(fill_cnt + 1'b1) == pre_n)) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (trig_hit) begin
                    state_next = (post_load == '0) ? S_READ : S_POST;
                end
            end
            S_POST: begin
                if (sample_valid && (post_cnt == ADDR_W'(1))) begin
                    state_next = S_READ;
                end
            end
            S_READ: begin
                if (rd_accept && rd_last) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Circular record RAM; contents need no reset
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    // Capture pointers, counters, trigger context and registered read port
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            pre_n      <= '0;
            trig_ptr   <= '0;
            post_cnt   <= '0;
            rd_addr    <= '0;
            fetch_cnt  <= '0;
            prev       <= '0;
            level      <= '0;
            slope      <= 1'b0;
            prev_valid <= 1'b0;
            addr_ok    <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            armed      <= 1'b0;
            triggered  <= 1'b0;
        end else begin
            if ((state == S_IDLE) && arm) begin
                level      <= $signed(trig_level);
                slope      <= trig_slope;
                pre_n      <= pretrig;
                wr_ptr     <= '0;
                fill_cnt   <= '0;
                prev_valid <= 1'b0;
                addr_ok    <= 1'b0;
                fetch_cnt  <= '0;
            end
            if (wr_en) begin
                wr_ptr     <= wr_ptr + 1'b1;
                prev       <= $signed(sample_in);
                prev_valid <= 1'b1;
            end
            if ((state == S_PRE) && sample_valid) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            if (trig_hit) begin
                trig_ptr <= wr_ptr;
                post_cnt <= post_load;
            end
            if ((state == S_POST) && sample_valid) begin
                post_cnt <= post_cnt - 1'b1;
            end
            // First READ cycle sets the oldest-sample address; data follows
            if ((state == S_READ) && !addr_ok) begin
                rd_addr <= trig_ptr - pre_n;
                addr_ok <= 1'b1;
            end
            if (rd_load) begin
                rd_data   <= mem[rd_addr];
                rd_valid  <= 1'b1;
                rd_last   <= (fetch_cnt == CNT_W'(DEPTH - 1));
                rd_addr   <= rd_addr + 1'b1;
                fetch_cnt <= fetch_cnt + 1'b1;
            end else if (rd_accept) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
            armed     <= (state_next == S_PRE) || (state_next == S_WAIT)
                         || (state_next == S_POST);
            triggered <= (state_next == S_POST) || (state_next == S_READ);
        end
    end

endmodule

// File: tb/tb_osc_trigger_capture.sv
// Scoreboard bench for osc_trigger_capture: captures of a 30-sample sine
// with expected records queued at stimulus time and checked by a monitor.
module tb_osc_trigger_capture;

    logic       clk;
    logic       rst;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       arm;
    logic [7:0] trig_level;
    logic       trig_slope;
    logic [5:0] pretrig;
    logic       armed;
    logic       triggered;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       rd_last;

    typedef struct {
        int data;
        bit last;
    } beat_t;

    int    errors = 0;
    int    checks = 0;
    int    accepts = 0;
    beat_t exp_q[$];
    int    rcv_all[$];
    int    tbl[30] = '{0, 16, 31, 45, 58, 67, 74, 77, 77, 74, 67, 58, 45, 31, 16,
                       0, -16, -31, -45, -58, -67, -74, -77, -77, -74, -67, -58,
                       -45, -31, -16};

    bit    stall_pend = 0;
    int    held_data = 0;
    int    held_last = 0;

    osc_trigger_capture dut (
        .Clk          (clk),
        .Rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .arm          (arm),
        .trig_level   (trig_level),
        .trig_slope   (trig_slope),
        .pretrig      (pretrig),
        .armed        (armed),
        .triggered    (triggered),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_last      (rd_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on each accepted beat, checks stall hold
    always @(negedge clk) begin
        if (rst) begin
            stall_pend = 0;
        end else begin
            if (stall_pend) begin
                chk("stall_valid_hold", int'(rd_valid), 1);
                chk("stall_data_hold", int'($signed(rd_data)), held_data);
                chk("stall_last_hold", int'(rd_last), held_last);
            end
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got data %0d with nothing expected",
                             $signed(rd_data));
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", int'($signed(rd_data)), e.data);
                    chk("beat_last", int'(rd_last), int'(e.last));
                end
                rcv_all.push_back(int'($signed(rd_data)));
                accepts++;
                stall_pend = 0;
            end else if (rd_valid) begin
                stall_pend = 1;
                held_data  = int'($signed(rd_data));
                held_last  = int'(rd_last);
            end else begin
                stall_pend = 0;
            end
        end
    end

    // One capture: stream the sine from index 0 with arm on index 0
    task automatic run_capture(input int level, input bit slope, input int pre,
                               input int period, input bit bp, input int t_exp,
                               input bit busy_arm, input int rst_after,
                               output int acc0);
        int  idx = 0;
        int  cyc = 0;
        bit  valid;
        bit  read_arm_done = 0;
        acc0 = accepts;
        if (rst_after < 0) begin
            for (int k = 0; k < 64; k++) begin
                beat_t b;
                b.data = tbl[(t_exp - pre + k) % 30];
                b.last = (k == 63);
                exp_q.push_back(b);
            end
        end
        while ((accepts - acc0 < 64) && (cyc < 1500)) begin
            valid        = (cyc % period == 0);
            sample_valid = valid;
            sample_in    = valid ? 8'(tbl[idx % 30]) : 8'd0;
            arm          = valid && (idx == 0);
            trig_level   = 8'(level);
            trig_slope   = slope;
            pretrig      = 6'(pre);
            if (busy_arm && valid && (idx == 20)) begin
                arm        = 1'b1;
                trig_level = 8'(-100);
                pretrig    = 6'd2;
            end
            if (busy_arm && !read_arm_done && (accepts - acc0 == 5)) begin
                arm           = 1'b1;
                trig_level    = 8'(-100);
                read_arm_done = 1;
            end
            rd_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            step();
            arm = 1'b0;
            if (valid && (idx == 0)) chk("armed_rise", int'(armed), 1);
            if (valid && (idx == t_exp - 1)) chk("not_yet_triggered", int'(triggered), 0);
            if (valid && (idx == t_exp)) chk("triggered_rise", int'(triggered), 1);
            if (valid) idx++;
            cyc++;
            if ((rst_after >= 0) && valid && (idx == t_exp + rst_after + 1)) begin
                sample_valid = 1'b0;
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk("rst_armed", int'(armed), 0);
                chk("rst_triggered", int'(triggered), 0);
                chk("rst_rd_valid", int'(rd_valid), 0);
                chk("rst_rd_last", int'(rd_last), 0);
                return;
            end
        end
        chk("accept_count", accepts - acc0, 64);
        chk("rd_valid_fall", int'(rd_valid), 0);
        chk("triggered_fall", int'(triggered), 0);
        chk("armed_idle", int'(armed), 0);
        sample_valid = 1'b0;
        rd_ready     = 1'b1;
        repeat (3) step();
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int a0;
        rst          = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        arm          = 1'b0;
        trig_level   = '0;
        trig_slope   = 1'b0;
        pretrig      = '0;
        rd_ready     = 1'b1;
        repeat (2) step();
        chk("reset_armed", int'(armed), 0);
        chk("reset_triggered", int'(triggered), 0);
        chk("reset_rd_valid", int'(rd_valid), 0);
        chk("reset_rd_last", int'(rd_last), 0);
        chk("reset_rd_data", int'(rd_data), 0);
        rst = 1'b0;
        step();

        // Rising through 40 with 8 pre-trigger samples
        run_capture(40, 1'b0, 8, 1, 1'b0, 33, 1'b0, -1, a0);
        chk("rise_beat0", rcv_all[a0], -67);
        chk("rise_beat8", rcv_all[a0 + 8], 45);
        chk("rise_beat63", rcv_all[a0 + 63], -31);

        // Falling through 0 with no pre-trigger samples
        run_capture(0, 1'b1, 0, 1, 1'b0, 15, 1'b0, -1, a0);
        chk("fall_beat0", rcv_all[a0], 0);
        chk("fall_beat1", rcv_all[a0 + 1], -16);

        // Backpressure 1,0,0,1
        run_capture(40, 1'b0, 8, 1, 1'b1, 33, 1'b0, -1, a0);
        chk("bp_beat8", rcv_all[a0 + 8], 45);

        // Sparse input, one sample every third cycle
        run_capture(40, 1'b0, 8, 3, 1'b0, 33, 1'b0, -1, a0);
        chk("sparse_beat0", rcv_all[a0], -67);

        // Arm pulses during WAIT_TRIG and READ are ignored
        run_capture(40, 1'b0, 8, 1, 1'b0, 33, 1'b1, -1, a0);
        chk("busy_beat63", rcv_all[a0 + 63], -31);

        // Reset 10 samples after the trigger, then a clean capture
        run_capture(40, 1'b0, 8, 1, 1'b0, 33, 1'b0, 10, a0);
        sample_valid = 1'b0;
        repeat (3) step();
        chk("post_rst_no_beats", accepts - a0, 0);
        run_capture(40, 1'b0, 8, 1, 1'b0, 33, 1'b0, -1, a0);
        chk("clean_beat0", rcv_all[a0], -67);
        chk("clean_beat8", rcv_all[a0 + 8], 45);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/osc_trigger_capture.md
# osc_trigger_capture

Trigger-and-capture stage sitting directly downstream of the sine sample generator in the oscilloscope datapath. It consumes the signed 8-bit sample stream and waits for a level crossing on a selected slope. It stores a fixed-length record containing a programmable number of pre-trigger samples, then streams the record out oldest-first to the display stage over a valid/ready handshake.

## Interface
- DATA_W, 8, sample width; two's-complement signed.
- DEPTH, 64, record length in samples; power of two, at least 4.
- ADDR_W, 6, log2(DEPTH).

Ports:
- Clk  in  1  rising-edge clock for all logic.
- Rst  in  1  synchronous, active-high reset.
- sample_in  in  DATA_W  signed input sample.
- sample_valid  in  1  sample_in is a new sample this cycle.
- arm  in  1  single-cycle request to start a capture; honoured only in IDLE.
- trig_level  in  DATA_W  signed trigger threshold; sampled on arm.
- trig_slope  in  1  0 = rising, 1 = falling; sampled on arm.
- pretrig  in  ADDR_W  number of pre-trigger samples, 0..DEPTH-1; sampled on arm.
- armed  out  1  high in PRE, WAIT_TRIG and POST.
- triggered  out  1  high in POST and READ.
- rd_data  out  DATA_W  record sample.
- rd_valid  out  1  rd_data is valid.
- rd_ready  in  1  consumer accepts rd_data.
- rd_last  out  1  qualifies the final (DEPTH-th) record sample.

## Operation
- Storage is a DEPTH x DATA_W circular RAM with write pointer wr_ptr. A write occurs on every sample_valid in PRE, WAIT_TRIG and POST, and wr_ptr then increments mod DEPTH.
- The state machine has five states: IDLE, PRE, WAIT_TRIG, POST and READ.
- IDLE → PRE on arm:
  - Latch trig_level, trig_slope and pretrig.
  - Clear wr_ptr, the fill counter and prev_valid.
  - If the latched pretrig is 0, go to WAIT_TRIG instead.
- PRE: counts written samples. Moves to WAIT_TRIG in the cycle the count reaches pretrig. The trigger is not evaluated in PRE.
- prev register: holds the most recent valid sample since arm. It is updated on every sample_valid in PRE, WAIT_TRIG and POST, and prev_valid is set on the first such sample.
- Trigger condition, evaluated in WAIT_TRIG on sample_valid with prev_valid = 1, using signed comparisons:
  - rising: prev < level and sample_in >= level.
  - falling: prev > level and sample_in <= level.
- On trigger:
  - The trigger sample is written, and trig_ptr is set to the wr_ptr used for that write.
  - Post counter is loaded with DEPTH-1-pretrig.
  - State becomes POST.
- POST: each valid sample decrements the post counter. When it is 0 at trigger time, or reaches 0, go to READ. The record therefore holds exactly pretrig + 1 + (DEPTH-1-pretrig) = DEPTH samples.
- READ:
  - Read address starts at (trig_ptr - pretrig) mod DEPTH and increments mod DEPTH per accepted beat.
  - Exactly DEPTH beats are produced.
  - Input samples are ignored.
- READ → IDLE in the cycle after the beat with rd_last accepted (rd_valid and rd_ready).
- arm outside IDLE is ignored.
- Rst in any state: state IDLE, all counters and pointers 0, prev_valid 0. RAM contents are don't-care. There is no partial readout after reset.

## Timing
- Reset values: armed = 0, triggered = 0, rd_valid = 0, rd_last = 0, rd_data = 0.
- armed rises one cycle after arm is sampled in IDLE.
- triggered rises one cycle after the trigger sample's sample_valid.
- The trigger test is combinational on sample_in against the registered prev.
- RAM read is registered. The first rd_valid is asserted 2 cycles after entering READ, with one cycle for address and one for data.
- With rd_ready held high, one beat per cycle, no bubbles.
- Handshake rules:
  - While rd_valid = 1 and rd_ready = 0, rd_data and rd_last hold stable.
  - rd_valid never drops until the beat is accepted.
  - The read address does not advance while stalled.
- rd_last is high only with the DEPTH-th beat.
- rd_valid, rd_last and triggered fall in the cycle after the final accept.
- Simultaneous events:
  - The sample that causes PRE → WAIT_TRIG is written but not trigger-tested.
  - A sample_valid gap (sample_valid = 0) holds all counters and prev.
  - Rst dominates arm and all handshakes.

## Test plan
- **Rising trigger with pretrig.** Stimulus: DEPTH 64; repeating 30-sample sine 0,16,31,45,58,67,74,77,77,74,67,58,45,31,16,0,-16,-31,-45,-58,-67,-74,-77,-77,-74,-67,-58,-45,-31,-16, one sample per cycle; level 40, rising, pretrig 8; arm coincident with sample index 0. Required response: trigger on stream index 33 (value 45). Readout is 64 beats starting at index 25 (-67); beat 8 = 45; the last beat is index 88 (-31) with rd_last.
- **Falling trigger at zero.** Same stream; level 0, falling, pretrig 0. Required response: trigger on the first 16→0 crossing after arm (index 15). Beat 0 = 0, beat 1 = -16, 64 beats total.
- **Backpressure.** Same capture as the rising test; toggle rd_ready 1,0,0,1 repeatedly. Required response: data held stable during stalls; beat sequence identical to the unstalled run; exactly 64 accepts.
- **Sparse input.** Same as the rising test with sample_valid asserted every third cycle. Required response: same record contents and trigger position as the rising test.
- **Arm while busy.** Pulse arm again during WAIT_TRIG and during READ. Required response: no restart, and record contents unchanged.
- **Reset mid-POST.** Rst asserted for one cycle 10 samples after the trigger. Required response: next cycle armed = 0, triggered = 0, rd_valid = 0. A subsequent arm performs a clean capture matching the rising test.
